// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - Writeback stage register, DstData select and RUN/HALTED control.
// Optional retire counter enabled by WB_RETIRE_CNT_EN.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic        mem_llb,
  input  logic        mem_lhb,
  input  logic        mem_halt,
  input  logic [3:0]  mem_dst,
  input  logic [15:0] mem_alu_out,
  input  logic [15:0] mem_rdata,
  input  logic [7:0]  mem_imm8,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  DstReg,
  output logic        WriteReg,
  output logic [15:0] DstData,
  output logic        llb,
  output logic        lhb,
  output logic        wb_valid,
`ifdef WB_RETIRE_CNT_EN
  output logic [15:0] retire_cnt,
`endif
  output logic        halt
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        llb;
    logic        lhb;
    logic        halt_i;
    logic [3:0]  dst;
    logic [15:0] alu_out;
    logic [15:0] rdata;
    logic [7:0]  imm8;
  } wb_t;

  wb_t        wb_q, wb_d;
  logic [0:0] state_q, state_d;
  logic       load;

  // Only RUN may change the register; HALTED freezes it until reset.
  assign load = (state_q == RUN) && !flush && !stall;

  always_comb begin
    wb_d    = wb_q;
    state_d = state_q;
    if (state_q == RUN) begin
      if (flush) begin
        wb_d = '0;
      end else if (!stall) begin
        wb_d.valid    = mem_valid;
        wb_d.regwrite = mem_regwrite;
        wb_d.memtoreg = mem_memtoreg;
        wb_d.llb      = mem_llb;
        wb_d.lhb      = mem_lhb;
        wb_d.halt_i   = mem_halt;
        wb_d.dst      = mem_dst;
        wb_d.alu_out  = mem_alu_out;
        wb_d.rdata    = mem_rdata;
        wb_d.imm8     = mem_imm8;
        // Halting as the halt instruction enters WB keeps its write suppressed.
        if (mem_valid && mem_halt) begin
          state_d = HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q    <= '0;
      state_q <= RUN;
    end else begin
      wb_q    <= wb_d;
      state_q <= state_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load && mem_valid && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;
`else
  logic unused_load;
  assign unused_load = load;
`endif

  always_comb begin
    if (wb_q.llb) begin
      DstData = {8'h00, wb_q.imm8};
    end else if (wb_q.lhb) begin
      DstData = {wb_q.imm8, 8'h00};
    end else if (wb_q.memtoreg) begin
      DstData = wb_q.rdata;
    end else begin
      DstData = wb_q.alu_out;
    end
  end

  assign DstReg   = wb_q.dst;
  assign WriteReg = wb_q.valid & wb_q.regwrite & (wb_q.dst != 4'h0) & (state_q == RUN);
  assign llb      = wb_q.valid & wb_q.llb;
  assign lhb      = wb_q.valid & wb_q.lhb & ~wb_q.llb;
  assign wb_valid = wb_q.valid;
  assign halt     = (state_q == HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - Directed scoreboard bench for wb_stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_regwrite, mem_memtoreg, mem_llb, mem_lhb, mem_halt;
  logic [3:0]  mem_dst;
  logic [15:0] mem_alu_out, mem_rdata;
  logic [7:0]  mem_imm8;
  logic        stall, flush;
  logic [3:0]  DstReg;
  logic        WriteReg, llb, lhb, wb_valid, halt;
  logic [15:0] DstData;
`ifdef WB_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_llb(mem_llb), .mem_lhb(mem_lhb), .mem_halt(mem_halt),
    .mem_dst(mem_dst), .mem_alu_out(mem_alu_out), .mem_rdata(mem_rdata), .mem_imm8(mem_imm8),
    .stall(stall), .flush(flush),
    .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
    .llb(llb), .lhb(lhb), .wb_valid(wb_valid),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .halt(halt)
  );

  typedef struct {
    logic [3:0]  dst;
    logic        wr;
    logic [15:0] data;
    logic        llb;
    logic        lhb;
    logic        valid;
    logic        halt;
    logic [15:0] cnt;
    logic        data_dc;
  } exp_t;

  exp_t  sb[$];
  string tags[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic        m_valid = 0, m_rw = 0, m_mtr = 0, m_llb = 0, m_lhb = 0, m_hlt = 0;
  logic [3:0]  m_dst = 0;
  logic [15:0] m_alu = 0, m_rd = 0;
  logic [7:0]  m_imm = 0;
  logic        m_halted = 0;
  logic        m_dc = 0;
  logic [15:0] m_cnt = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst_n, input logic stl, input logic fl,
                      input logic v, input logic rw, input logic mtr,
                      input logic l, input logic h, input logic hl,
                      input logic [3:0] d, input logic [15:0] alu,
                      input logic [15:0] rd, input logic [7:0] imm,
                      input string tag, input bit do_check = 1'b1);
    exp_t e;
    string t;
    rst = rst_n; stall = stl; flush = fl;
    mem_valid = v; mem_regwrite = rw; mem_memtoreg = mtr;
    mem_llb = l; mem_lhb = h; mem_halt = hl;
    mem_dst = d; mem_alu_out = alu; mem_rdata = rd; mem_imm8 = imm;

    if (!rst_n) begin
      {m_valid, m_rw, m_mtr, m_llb, m_lhb, m_hlt} = '0;
      m_dst = 0; m_alu = 0; m_rd = 0; m_imm = 0;
      m_halted = 0; m_cnt = 0; m_dc = 0;
    end else if (m_halted) begin
    end else if (fl) begin
      {m_valid, m_rw, m_mtr, m_llb, m_lhb, m_hlt} = '0;
      m_dc = 1;
    end else if (!stl) begin
      m_valid = v; m_rw = rw; m_mtr = mtr; m_llb = l; m_lhb = h; m_hlt = hl;
      m_dst = d; m_alu = alu; m_rd = rd; m_imm = imm; m_dc = 0;
      if (v && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (v && hl) m_halted = 1;
    end

    e.dst     = m_dst;
    e.valid   = m_valid;
    e.halt    = m_halted;
    e.wr      = m_valid & m_rw & (m_dst != 0) & ~m_halted;
    e.llb     = m_valid & m_llb;
    e.lhb     = m_valid & m_lhb & ~m_llb;
    e.data    = m_llb ? {8'h00, m_imm} : m_lhb ? {m_imm, 8'h00} : m_mtr ? m_rd : m_alu;
    e.cnt     = m_cnt;
    e.data_dc = m_dc;
    if (do_check) begin
      sb.push_back(e);
      tags.push_back(tag);
    end

    @(posedge clk);
    #1;
    if (do_check) begin
      e = sb.pop_front();
      t = tags.pop_front();
      check({t, ".wb_valid"}, {15'd0, wb_valid}, {15'd0, e.valid});
      check({t, ".WriteReg"}, {15'd0, WriteReg}, {15'd0, e.wr});
      check({t, ".llb"},      {15'd0, llb},      {15'd0, e.llb});
      check({t, ".lhb"},      {15'd0, lhb},      {15'd0, e.lhb});
      check({t, ".halt"},     {15'd0, halt},     {15'd0, e.halt});
      if (!e.data_dc) begin
        check({t, ".DstReg"},  {12'd0, DstReg}, {12'd0, e.dst});
        check({t, ".DstData"}, DstData, e.data);
      end
`ifdef WB_RETIRE_CNT_EN
      check({t, ".retire_cnt"}, retire_cnt, e.cnt);
`endif
    end
  endtask

  initial begin
    // args: rst stall flush valid rw mtr llb lhb halt dst alu rdata imm8 tag
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 16'h0000, 16'h0000, 8'h00, "reset0");
    step(0, 1, 1, 1, 1, 1, 1, 1, 1, 4'hF, 16'hFFFF, 16'hFFFF, 8'hFF, "reset_dominates");

    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 4'h3, 16'h1234, 16'h9999, 8'h11, "load");
    step(1, 0, 0, 1, 1, 0, 1, 0, 0, 4'h1, 16'h1111, 16'h2222, 8'hAB, "llb");
    step(1, 0, 0, 1, 1, 0, 0, 1, 0, 4'h2, 16'h1111, 16'h2222, 8'hCD, "lhb");
    step(1, 0, 0, 1, 1, 0, 1, 1, 0, 4'h6, 16'h1111, 16'h2222, 8'h12, "llb_lhb");
    step(1, 0, 0, 1, 1, 1, 0, 0, 0, 4'h5, 16'h3333, 16'hBEEF, 8'h00, "memtoreg");
    step(1, 0, 0, 1, 1, 1, 0, 0, 0, 4'h0, 16'h3333, 16'hBEEF, 8'h00, "r0_suppress");
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 4'h9, 16'h7777, 16'h0000, 8'h00, "invalid");

    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 4'h7, 16'h5555, 16'h0000, 8'h00, "pre_stall");
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, 1, 1, 0, 0, 0, 4'h8 + 4'(i), 16'hAAAA, 16'hC0DE, 8'h44, "stall");
    step(1, 1, 1, 1, 1, 0, 0, 0, 0, 4'hA, 16'h6666, 16'h0000, 8'h00, "stall_flush");
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 4'h2, 16'h0F0F, 16'h0000, 8'h00, "after_flush");

    step(1, 0, 0, 1, 1, 0, 0, 0, 1, 4'h4, 16'hDEAD, 16'h0000, 8'h00, "halt_insn");
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 4'h3, 16'h4321, 16'h0000, 8'h00, "halted_traffic");
    step(1, 1, 1, 1, 1, 0, 1, 0, 0, 4'h1, 16'h1111, 16'h0000, 8'h99, "halted_flush");
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 4'h3, 16'h4321, 16'h0000, 8'h00, "halt_reset");
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 4'hC, 16'h2468, 16'h0000, 8'h00, "run_after_reset");

`ifdef WB_RETIRE_CNT_EN
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 16'h0000, 16'h0000, 8'h00, "sat_reset");
    for (int i = 0; i < 65533; i++)
      step(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h1, 16'h0001, 16'h0000, 8'h00, "sat_fill", 1'b0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h1, 16'h0001, 16'h0000, 8'h00, "sat_fffe");
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h1, 16'h0001, 16'h0000, 8'h00, "sat_hold");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
